// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and controller states for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_OR   = 4'd2;
   localparam logic [3:0] OP_XOR  = 4'd3;
   localparam logic [3:0] OP_PASS = 4'd4;
   localparam logic [3:0] OP_SUB  = 4'd5;
   localparam logic [3:0] OP_ADC  = 4'd6;
   localparam logic [3:0] OP_NOT  = 4'd7;
   localparam logic [3:0] OP_SHL  = 4'd8;
   localparam logic [3:0] OP_SHR  = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } alu_state_t;

   function automatic logic [3:0] packFlags(input logic v, input logic n, input logic z, input logic c);
      logic [3:0] f;
      f         = '0;
      f[FLAG_V] = v;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      return f;
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: operands captured on start_i, one iteration per cycle.
// done_o and product_o describe the final iteration so the caller can load on that same edge.
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);

   localparam logic [WIDTH-1:0] LastIter = WIDTH'(WIDTH - 1);

   logic               busyQ, busyD;
   logic [WIDTH-1:0]   countQ, countD;
   logic [WIDTH-1:0]   mcandQ, mcandD;
   logic [2*WIDTH-1:0] accQ, accD;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     partial;
   logic [2*WIDTH-1:0] shifted;

   // The multiplier lives in the low half of the accumulator and is consumed LSB first;
   // the carry of each partial add drops into the top bit as the pair shifts right.
   always_comb begin
      addend  = accQ[0] ? mcandQ : '0;
      partial = {1'b0, accQ[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      shifted = {partial, accQ[WIDTH-1:1]};
   end

   assign done_o    = busyQ && (countQ == LastIter);
   assign product_o = shifted;

   always_comb begin
      busyD  = busyQ;
      countD = countQ;
      mcandD = mcandQ;
      accD   = accQ;
      if (start_i) begin
         busyD  = 1'b1;
         countD = '0;
         mcandD = a_i;
         accD   = {{WIDTH{1'b0}}, b_i};
      end else if (busyQ) begin
         accD   = shifted;
         countD = countQ + WIDTH'(1);
         if (done_o) begin
            busyD = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busyQ  <= 1'b0;
         countQ <= '0;
         mcandQ <= '0;
         accQ   <= '0;
      end else begin
         busyQ  <= busyD;
         countQ <= countD;
         mcandQ <= mcandD;
         accQ   <= accD;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, persistent {V,N,Z,C} flags and an optional
// multi-cycle multiplier; single-cycle ops present their result the cycle after acceptance.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_SEL,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [WIDTH-1:0] ALU_OUT,
   output logic [WIDTH-1:0] ALU_OUT_HI,
   output logic [3:0]       FLAGS,
   output logic             OUT_VALID,
   input  logic             OUT_READY
);

   alu_state_t         stateQ, stateD;
   logic [WIDTH-1:0]   resLoQ, resLoD;
   logic [WIDTH-1:0]   resHiQ, resHiD;
   logic [3:0]         flagsQ, flagsD;
   logic               outValidQ, outValidD;

   logic [WIDTH:0]     sum, adcSum, diff;
   logic [WIDTH-1:0]   opRes;
   logic               opC, opV;
   logic               isMul, accept, mulStart, mulDone;
   logic [2*WIDTH-1:0] mulProduct;

   assign IN_READY   = (stateQ == ST_IDLE) && (!outValidQ || OUT_READY);
   assign accept     = IN_VALID && IN_READY;
   assign isMul      = MUL_EN && (ALU_SEL == OP_MUL);
   assign ALU_OUT    = resLoQ;
   assign ALU_OUT_HI = resHiQ;
   assign FLAGS      = flagsQ;
   assign OUT_VALID  = outValidQ;

   // Arithmetic is done one bit wider so the top bit is the carry (or borrow for SUB).
   always_comb begin
      sum    = {1'b0, A} + {1'b0, B};
      adcSum = sum + {{WIDTH{1'b0}}, flagsQ[FLAG_C]};
      diff   = {1'b0, A} - {1'b0, B};
      opRes  = '0;
      opC    = 1'b0;
      opV    = 1'b0;
      case (ALU_SEL)
         OP_AND:  opRes = A & B;
         OP_OR:   opRes = A | B;
         OP_XOR:  opRes = A ^ B;
         OP_PASS: opRes = B;
         OP_NOT:  opRes = ~A;
         OP_SUB: begin
            opRes = diff[WIDTH-1:0];
            opC   = diff[WIDTH];
            opV   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         OP_ADC: begin
            opRes = adcSum[WIDTH-1:0];
            opC   = adcSum[WIDTH];
            opV   = (A[WIDTH-1] == B[WIDTH-1]) && (adcSum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SHL: begin
            opRes = {A[WIDTH-2:0], 1'b0};
            opC   = A[WIDTH-1];
         end
         OP_SHR: begin
            opRes = {1'b0, A[WIDTH-1:1]};
            opC   = A[0];
         end
         // ADD, the aliased opcodes 11-15, and MUL when no multiplier is built.
         default: begin
            opRes = sum[WIDTH-1:0];
            opC   = sum[WIDTH];
            opV   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
      endcase
   end

   // A result drains whenever the consumer is ready; a load on the same edge overrides that.
   always_comb begin
      stateD    = stateQ;
      resLoD    = resLoQ;
      resHiD    = resHiQ;
      flagsD    = flagsQ;
      outValidD = outValidQ;
      mulStart  = 1'b0;
      if (outValidQ && OUT_READY) begin
         outValidD = 1'b0;
      end
      case (stateQ)
         ST_IDLE: begin
            if (accept) begin
               if (isMul) begin
                  mulStart = 1'b1;
                  stateD   = ST_MUL_BUSY;
               end else begin
                  resLoD    = opRes;
                  resHiD    = '0;
                  flagsD    = packFlags(opV, opRes[WIDTH-1], opRes == '0, opC);
                  outValidD = 1'b1;
               end
            end
         end
         ST_MUL_BUSY: begin
            if (mulDone) begin
               resLoD    = mulProduct[WIDTH-1:0];
               resHiD    = mulProduct[2*WIDTH-1:WIDTH];
               flagsD    = packFlags(1'b0, mulProduct[2*WIDTH-1], mulProduct == '0,
                                     |mulProduct[2*WIDTH-1:WIDTH]);
               outValidD = 1'b1;
               stateD    = ST_IDLE;
            end
         end
         default: stateD = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stateQ    <= ST_IDLE;
         resLoQ    <= '0;
         resHiQ    <= '0;
         flagsQ    <= '0;
         outValidQ <= 1'b0;
      end else begin
         stateQ    <= stateD;
         resLoQ    <= resLoD;
         resHiQ    <= resHiD;
         flagsQ    <= flagsD;
         outValidQ <= outValidD;
      end
   end

   generate
      if (MUL_EN) begin : gMul
         alu_mul_seq #(
            .WIDTH(WIDTH)
         ) uMul (
            .clk_i    (CLK),
            .rst_ni   (RST_N),
            .start_i  (mulStart),
            .a_i      (A),
            .b_i      (B),
            .done_o   (mulDone),
            .product_o(mulProduct)
         );
      end else begin : gNoMul
         assign mulDone    = 1'b0;
         assign mulProduct = '0;
      end
   endgenerate

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8, multiplier present): vector table for single-cycle
// ops plus hand-written multiply, back-pressure and reset-abort sequences.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 8;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic [W-1:0]  A, B;
   logic [3:0]    ALU_SEL;
   logic          IN_VALID;
   logic          IN_READY;
   logic [W-1:0]  ALU_OUT, ALU_OUT_HI;
   logic [3:0]    FLAGS;
   logic          OUT_VALID;
   logic          OUT_READY;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [3:0] sel;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] expOut;
      logic [3:0] expFlags;
   } vec_t;

   vec_t vecs[15];

   alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .A         (A),
      .B         (B),
      .ALU_SEL   (ALU_SEL),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .ALU_OUT   (ALU_OUT),
      .ALU_OUT_HI(ALU_OUT_HI),
      .FLAGS     (FLAGS),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic applyStimulus(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
      int n;
      n = 0;
      while (!IN_READY && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (!IN_READY) checkOutput("in_ready_wait", {31'b0, IN_READY}, 32'h1);
      ALU_SEL  = sel;
      A        = a;
      B        = b;
      IN_VALID = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      IN_VALID = 1'b0;
   endtask

   initial begin
      logic busyBad;

      // {sel, a, b, expOut, expFlags={V,N,Z,C}}
      vecs[0]  = '{OP_ADD,  8'hF0, 8'h20, 8'h10, 4'b0001};
      vecs[1]  = '{OP_ADC,  8'h01, 8'h01, 8'h03, 4'b0000};
      vecs[2]  = '{OP_SUB,  8'h05, 8'h05, 8'h00, 4'b0010};
      vecs[3]  = '{OP_SUB,  8'h80, 8'h01, 8'h7F, 4'b1000};
      vecs[4]  = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 4'b0000};
      vecs[5]  = '{OP_OR,   8'h0F, 8'h80, 8'h8F, 4'b0100};
      vecs[6]  = '{OP_XOR,  8'hFF, 8'hFF, 8'h00, 4'b0010};
      vecs[7]  = '{OP_PASS, 8'h11, 8'h80, 8'h80, 4'b0100};
      vecs[8]  = '{OP_NOT,  8'h0F, 8'h00, 8'hF0, 4'b0100};
      vecs[9]  = '{OP_SHL,  8'h81, 8'h00, 8'h02, 4'b0001};
      vecs[10] = '{OP_SHR,  8'h81, 8'h00, 8'h40, 4'b0001};
      vecs[11] = '{OP_SUB,  8'h01, 8'h02, 8'hFF, 4'b0101};
      vecs[12] = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 4'b1100};
      vecs[13] = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 4'b0011};
      vecs[14] = '{OP_ADC,  8'h00, 8'h00, 8'h01, 4'b0000};

      RST_N     = 1'b0;
      A         = '0;
      B         = '0;
      ALU_SEL   = '0;
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      repeat (2) @(negedge CLK);
      checkOutput("rst_out",       {24'b0, ALU_OUT},    32'h0);
      checkOutput("rst_out_hi",    {24'b0, ALU_OUT_HI}, 32'h0);
      checkOutput("rst_flags",     {28'b0, FLAGS},      32'h0);
      checkOutput("rst_out_valid", {31'b0, OUT_VALID},  32'h0);
      RST_N = 1'b1;
      @(negedge CLK);
      checkOutput("rel_in_ready",  {31'b0, IN_READY},   32'h1);

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].sel, vecs[i].a, vecs[i].b);
         checkOutput($sformatf("vec%0d_valid", i), {31'b0, OUT_VALID},  32'h1);
         checkOutput($sformatf("vec%0d_out", i),   {24'b0, ALU_OUT},    {24'b0, vecs[i].expOut});
         checkOutput($sformatf("vec%0d_hi", i),    {24'b0, ALU_OUT_HI}, 32'h0);
         checkOutput($sformatf("vec%0d_flags", i), {28'b0, FLAGS},      {28'b0, vecs[i].expFlags});
      end

      // Multiply 0xFF*0xFF with operands scrambled after acceptance.
      applyStimulus(OP_MUL, 8'hFF, 8'hFF);
      A       = 8'h00;
      B       = 8'h00;
      ALU_SEL = OP_ADD;
      for (int i = 0; i < W; i++) begin
         if (i > 0) @(negedge CLK);
         checkOutput($sformatf("mul_busy%0d_in_ready", i),  {31'b0, IN_READY},  32'h0);
         checkOutput($sformatf("mul_busy%0d_out_valid", i), {31'b0, OUT_VALID}, 32'h0);
      end
      @(negedge CLK);
      checkOutput("mul_valid",    {31'b0, OUT_VALID},  32'h1);
      checkOutput("mul_out",      {24'b0, ALU_OUT},    32'h01);
      checkOutput("mul_hi",       {24'b0, ALU_OUT_HI}, 32'hFE);
      checkOutput("mul_flags",    {28'b0, FLAGS},      32'h5);
      checkOutput("mul_in_ready", {31'b0, IN_READY},   32'h1);
      @(negedge CLK);
      checkOutput("mul_drained",  {31'b0, OUT_VALID},  32'h0);

      // Back-pressure holds the XOR result and blocks a waiting op until drained.
      OUT_READY = 1'b0;
      applyStimulus(OP_XOR, 8'hAA, 8'h0F);
      checkOutput("bp_valid",    {31'b0, OUT_VALID},  32'h1);
      checkOutput("bp_out",      {24'b0, ALU_OUT},    32'hA5);
      checkOutput("bp_hi",       {24'b0, ALU_OUT_HI}, 32'h0);
      checkOutput("bp_flags",    {28'b0, FLAGS},      32'h4);
      checkOutput("bp_in_ready", {31'b0, IN_READY},   32'h0);
      ALU_SEL  = OP_ADD;
      A        = 8'h01;
      B        = 8'h02;
      IN_VALID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         checkOutput($sformatf("bp_hold%0d_out", i),      {24'b0, ALU_OUT},   32'hA5);
         checkOutput($sformatf("bp_hold%0d_valid", i),    {31'b0, OUT_VALID}, 32'h1);
         checkOutput($sformatf("bp_hold%0d_in_ready", i), {31'b0, IN_READY},  32'h0);
      end
      OUT_READY = 1'b1;
      #1;
      checkOutput("bp_release_in_ready", {31'b0, IN_READY}, 32'h1);
      @(posedge CLK);
      @(negedge CLK);
      IN_VALID = 1'b0;
      checkOutput("bp_next_valid", {31'b0, OUT_VALID}, 32'h1);
      checkOutput("bp_next_out",   {24'b0, ALU_OUT},   32'h03);
      checkOutput("bp_next_flags", {28'b0, FLAGS},     32'h0);
      @(negedge CLK);
      checkOutput("bp_next_drained", {31'b0, OUT_VALID}, 32'h0);

      // Reset three cycles into a multiply aborts it and clears outputs at once.
      applyStimulus(OP_SUB, 8'h01, 8'h02);
      applyStimulus(OP_MUL, 8'h0F, 8'h03);
      repeat (2) @(negedge CLK);
      RST_N = 1'b0;
      #1;
      checkOutput("abort_out",       {24'b0, ALU_OUT},    32'h0);
      checkOutput("abort_out_hi",    {24'b0, ALU_OUT_HI}, 32'h0);
      checkOutput("abort_flags",     {28'b0, FLAGS},      32'h0);
      checkOutput("abort_out_valid", {31'b0, OUT_VALID},  32'h0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      #1;
      checkOutput("abort_in_ready", {31'b0, IN_READY}, 32'h1);
      busyBad = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge CLK);
         if (OUT_VALID !== 1'b0) busyBad = 1'b1;
      end
      checkOutput("abort_no_stale_result", {31'b0, busyBad}, 32'h0);
      applyStimulus(OP_ADD, 8'h01, 8'h02);
      checkOutput("abort_add_valid", {31'b0, OUT_VALID},  32'h1);
      checkOutput("abort_add_out",   {24'b0, ALU_OUT},    32'h03);
      checkOutput("abort_add_hi",    {24'b0, ALU_OUT_HI}, 32'h0);
      checkOutput("abort_add_flags", {28'b0, FLAGS},      32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
